// File: rtl/wb_regfile.sv
// Write-back stage register file: 32x32 storage, two combinational read ports
// with same-cycle write-through bypass, and a committed-write counter.

module wb_regfile_rdport #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                      rst,
  input  logic [AW-1:0]             addr,
  input  logic [DEPTH-1:0][DW-1:0]  mem,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [DW-1:0]             wr_data,
  output logic [DW-1:0]             data
);
  // Reads are forced to zero while reset is held, which also disables bypass.
  always_comb begin
    data = '0;
    if (rst) begin
      if (wr_en && (wr_addr == addr)) data = wr_data;
      else                            data = mem[addr];
    end
  end
endmodule

module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_lwsrc,
  input  logic [4:0]  wb_write_addr_o,
  input  logic        wb_reg_write,
  input  logic [31:0] wb_movsrc_result,
  input  logic [31:0] wb_DM_out,
  input  logic [4:0]  read_addr1,
  input  logic [4:0]  read_addr2,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  output logic [31:0] wb_write_data,
  output logic [31:0] retire_cnt
);
  localparam int DEPTH  = 32;
  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int NUM_RD = 2;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [31:0]              cnt_q;
  wr_req_t                  wr;
  logic [NUM_RD-1:0][AW-1:0] rd_addr;
  logic [NUM_RD-1:0][DW-1:0] rd_data;

  assign wb_write_data = wb_lwsrc ? wb_DM_out : wb_movsrc_result;
  assign wr.en   = wb_reg_write;
  assign wr.addr = wb_write_addr_o;
  assign wr.data = wb_write_data;

  // Reset wins over a concurrent write; entry 0 is an ordinary register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem   <= '0;
      cnt_q <= '0;
    end else if (wr.en) begin
      mem[wr.addr] <= wr.data;
      cnt_q        <= cnt_q + 32'd1;
    end
  end

  assign retire_cnt = cnt_q;
  assign rd_addr[0] = read_addr1;
  assign rd_addr[1] = read_addr2;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    wb_regfile_rdport #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_rd (
      .rst     (rst),
      .addr    (rd_addr[p]),
      .mem     (mem),
      .wr_en   (wr.en),
      .wr_addr (wr.addr),
      .wr_data (wr.data),
      .data    (rd_data[p])
    );
  end

  assign read_data1 = rd_data[0];
  assign read_data2 = rd_data[1];
endmodule
